// File: rtl/cmult_pkg.sv
// cmult_pkg: width helpers, rounding constant and {real, imag} packing
// shared by complx_mult_pipe and complx_round_sat (components <= 32 bits).
package cmult_pkg;

  // ar+ai and br+bi_eff, including -(-2^(W-1))
  function automatic int pre_w(int w);
    return w + 1;
  endfunction

  // (W+1) x (W+1) signed product
  function automatic int prod_w(int w);
    return 2 * w + 2;
  endfunction

  // p3 - p1 - p2 with headroom
  function automatic int sum_w(int w);
    return 2 * w + 4;
  endfunction

  // half an output LSB, zero when no scaling
  function automatic longint rnd_const(int sh);
    return (sh > 0) ? (longint'(1) <<< (sh - 1))
                    : longint'(0);
  endfunction

  function automatic logic [63:0] cplx_pack(
    logic [31:0] re,
    logic [31:0] im,
    int          w
  );
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((64'(re) & mask) << w)
         | (64'(im) & mask);
  endfunction

  function automatic logic [31:0] cplx_re(
    logic [63:0] v,
    int          w
  );
    return 32'(v >> w);
  endfunction

  function automatic logic [31:0] cplx_im(
    logic [63:0] v,
    int          w
  );
    return 32'(v);
  endfunction

endpackage

// File: rtl/complx_round_sat.sv
// complx_round_sat: round-half-up, arithmetic shift and reduce one component.
// din (IN_W signed) -> dout (OUT_W signed); saturates if CMULT_SAT_EN, else wraps.
module complx_round_sat
  import cmult_pkg::*;
#(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // one spare bit so the rounding add never overflows
  localparam int XW = (IN_W + 1 > OUT_W)
                    ? IN_W + 1 : OUT_W + 1;

  localparam logic signed [XW-1:0] RND =
    XW'(rnd_const(SHIFT));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shr;

  always_comb begin
    ext = XW'(din);
    rnd = ext + RND;
    shr = rnd >>> SHIFT;
  end

`ifdef CMULT_SAT_EN
  localparam logic [OUT_W-1:0] MAXV =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV =
    {1'b1, {(OUT_W-1){1'b0}}};

  // fits when all bits from the output sign up agree
  logic fits;

  always_comb begin
    fits = (&shr[XW-1:OUT_W-1])
         | (~|shr[XW-1:OUT_W-1]);
    if (fits)
      dout = shr[OUT_W-1:0];
    else if (shr[XW-1])
      dout = MINV;
    else
      dout = MAXV;
  end
`else
  logic unused_hi;
  assign unused_hi = ^shr[XW-1:OUT_W];

  always_comb begin
    dout = shr[OUT_W-1:0];
  end
`endif

endmodule

// File: rtl/complx_mult_pipe.sv
// complx_mult_pipe: 3-stage a*b / a*conj(b) with 3-multiplier form, valid/ready.
// in: a,b {re,im}, conj_b; out {re,im}; macro CMULT_SAT_EN selects saturation.
module complx_mult_pipe
  import cmult_pkg::*;
#(
  parameter int WIDTH_R_I = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WIDTH_R_I-1:0]   a,
  input  logic [2*WIDTH_R_I-1:0]   b,
  input  logic                     conj_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*OUT_W-1:0]       out
);

  localparam int W   = WIDTH_R_I;
  localparam int AW  = pre_w(W);
  localparam int PW  = prod_w(W);
  localparam int SW  = sum_w(W);
  localparam int OW2 = 2 * OUT_W;

  // whole pipe moves together; a drained output frees it
  logic adv;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  logic signed [W-1:0]  ar;
  logic signed [W-1:0]  ai;
  logic signed [W-1:0]  br;
  logic signed [W-1:0]  bi;
  logic signed [AW-1:0] bi_eff;
  logic signed [AW-1:0] sa;
  logic signed [AW-1:0] sb;

  always_comb begin
    ar = W'(cplx_re(64'(a), W));
    ai = W'(cplx_im(64'(a), W));
    br = W'(cplx_re(64'(b), W));
    bi = W'(cplx_im(64'(b), W));
    bi_eff = conj_b ? -AW'(bi) : AW'(bi);
    sa = AW'(ar) + AW'(ai);
    sb = AW'(br) + bi_eff;
  end

  logic                 s1_v;
  logic signed [W-1:0]  s1_ar;
  logic signed [W-1:0]  s1_ai;
  logic signed [W-1:0]  s1_br;
  logic signed [AW-1:0] s1_bi;
  logic signed [AW-1:0] s1_sa;
  logic signed [AW-1:0] s1_sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s1_ar <= '0;
      s1_ai <= '0;
      s1_br <= '0;
      s1_bi <= '0;
      s1_sa <= '0;
      s1_sb <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_ar <= ar;
        s1_ai <= ai;
        s1_br <= br;
        s1_bi <= bi_eff;
        s1_sa <= sa;
        s1_sb <= sb;
      end
    end
  end

  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;
  logic signed [PW-1:0] p3;

  always_comb begin
    p1 = PW'(s1_ar) * PW'(s1_br);
    p2 = PW'(s1_ai) * PW'(s1_bi);
    p3 = PW'(s1_sa) * PW'(s1_sb);
  end

  logic                 s2_v;
  logic signed [PW-1:0] s2_p1;
  logic signed [PW-1:0] s2_p2;
  logic signed [PW-1:0] s2_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_p1 <= '0;
      s2_p2 <= '0;
      s2_p3 <= '0;
    end else if (adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p1 <= p1;
        s2_p2 <= p2;
        s2_p3 <= p3;
      end
    end
  end

  logic signed [SW-1:0]    re_full;
  logic signed [SW-1:0]    im_full;
  logic signed [OUT_W-1:0] re_rs;
  logic signed [OUT_W-1:0] im_rs;

  // imag = ar*bi + ai*br recovered from the shared products
  always_comb begin
    re_full = SW'(s2_p1) - SW'(s2_p2);
    im_full = SW'(s2_p3) - SW'(s2_p1)
            - SW'(s2_p2);
  end

  complx_round_sat #(
    .IN_W  (SW),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rs_re (
    .din  (re_full),
    .dout (re_rs)
  );

  complx_round_sat #(
    .IN_W  (SW),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rs_im (
    .din  (im_full),
    .dout (im_rs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (adv) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out <= OW2'(cplx_pack(32'(re_rs),
                              32'(im_rs),
                              OUT_W));
      end
    end
  end

endmodule

// File: tb/tb_complx_mult_pipe.sv
// tb_complx_mult_pipe: directed vectors, random streams with backpressure
// and mid-flight reset against a longint reference model.
module tb_complx_mult_pipe;

  localparam int SHIFT = 15;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        conj_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int tests  = 0;
  int failed = 0;
  int sent   = 0;
  int got    = 0;

  logic [31:0] exp_q[$];

  complx_mult_pipe #(
    .WIDTH_R_I (16),
    .OUT_W     (16),
    .SHIFT     (SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .conj_b    (conj_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] reduce(longint v);
    longint r;
    r = (v + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef CMULT_SAT_EN
    if (r > 32767)
      r = 32767;
    else if (r < -32768)
      r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [31:0] model(
    logic [31:0] av,
    logic [31:0] bv,
    logic        cj
  );
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(av[31:16]));
    ai = longint'($signed(av[15:0]));
    br = longint'($signed(bv[31:16]));
    bi = longint'($signed(bv[15:0]));
    if (cj) bi = -bi;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {reduce(re), reduce(im)};
  endfunction

  task automatic check(
    string       tag,
    logic [63:0] obs,
    logic [63:0] expv
  );
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, expv);
    end
  endtask

  // one clock: score handshakes mid-cycle, return at posedge+1
  task automatic tick();
    logic fire;
    @(negedge clk);
    fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got++;
      if (exp_q.size() == 0)
        check("stream_q", 64'(exp_q.size()), 64'd1);
      else
        check("stream", 64'(out),
              64'(exp_q.pop_front()));
    end
    if (fire) exp_q.push_back(model(a, b, conj_b));
    @(posedge clk);
    #1;
    if (fire) begin
      in_valid = 1'b0;
      sent++;
    end
  endtask

  task automatic directed(
    string       tag,
    logic [31:0] av,
    logic [31:0] bv,
    logic        cj,
    logic [31:0] expv
  );
    int lat;
    a         = av;
    b         = bv;
    conj_b    = cj;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check(tag, 64'(out), 64'(expv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        prev_stall;
    logic [31:0] prev_out;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    conj_b    = 1'b0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("basic", 32'h4000_4000,
             32'h4000_C000, 1'b0, 32'h4000_0000);
    directed("conj", 32'h4000_4000,
             32'h4000_C000, 1'b1, 32'h0000_4000);
`ifdef CMULT_SAT_EN
    directed("ovf", 32'h8000_0000,
             32'h8000_0000, 1'b0, 32'h7FFF_0000);
`else
    directed("ovf", 32'h8000_0000,
             32'h8000_0000, 1'b0, 32'h8000_0000);
`endif
    directed("round", 32'h0001_0000,
             32'h4000_0000, 1'b0, 32'h0001_0000);
    directed("conj_min", 32'h7FFF_8000,
             32'h8000_8000, 1'b1,
             model(32'h7FFF_8000, 32'h8000_8000, 1'b1));

    // 10 back-to-back pairs, output stalled in cycles 4..8
    exp_q.delete();
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 10 && !in_valid) begin
        a        = $urandom;
        b        = $urandom;
        conj_b   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_out", 64'(out), 64'(prev_out));
      end
      if (!out_ready && out_valid)
        check("stall_in_ready", 64'(in_ready), 64'd0);
      prev_stall = !out_ready && out_valid;
      prev_out   = out;
      tick();
    end
    check("bp_count", 64'(got), 64'd10);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // random valid gaps and random downstream stalls
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 30; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 30 && !in_valid &&
          $urandom_range(0, 3) != 0) begin
        a        = $urandom;
        b        = $urandom;
        conj_b   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("rand_count", 64'(got), 64'd30);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // three results in flight, then reset
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = $urandom;
      b        = $urandom;
      conj_b   = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("flight_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out", 64'(out), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_idle", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    directed("post_rst", 32'h4000_4000,
             32'h4000_C000, 1'b0, 32'h4000_0000);

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule

// File: doc/complx_mult_pipe.md
COMPLX_MULT_PIPE -- requirements
Module: complx_mult_pipe

Interface
REQ-001 Parameter WIDTH_R_I, default 16: signed width of each real/imag input component.
REQ-002 Parameter OUT_W, default 16: signed width of each real/imag output component.
REQ-003 Parameter SHIFT, default 15: arithmetic right shift applied to full-precision results; range 0..2*WIDTH_R_I.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1: a, b, conj_b carry a valid operand pair.
REQ-007 in_ready  output  1: block accepts an operand pair this cycle.
REQ-008 a  input  2*WIDTH_R_I: {ar, ai}, real in upper half, two's complement.
REQ-009 b  input  2*WIDTH_R_I: {br, bi}, same packing as a.
REQ-010 conj_b  input  1: 1 = compute a*conj(b); 0 = compute a*b; sampled with the operand pair.
REQ-011 out_valid  output  1: out holds a valid result.
REQ-012 out_ready  input  1: downstream accepts out this cycle.
REQ-013 out  output  2*OUT_W: {real, imag}, two's complement.

Function
REQ-014 Transfers occur on a cycle where valid and ready are both 1; the handshake applies on both ports.
REQ-015 The pipeline has 3 register stages: S1 operands plus pre-adds, S2 three products, S3 combine plus round/saturate.
REQ-016 Latency is exactly 3 cycles from input transfer to out_valid=1 when out_ready stays 1.
REQ-017 Sustained throughput is one result per cycle.
REQ-018 Negation for conj_b: bi_eff = -bi when conj_b=1, computed at WIDTH_R_I+1 bits so that -(-2^(W-1)) is exact.
REQ-019 The three products are computed at full precision with no intermediate truncation:
- p1 = ar*br
- p2 = ai*bi_eff
- p3 = (ar+ai)*(br+bi_eff)
REQ-020 Full-precision outputs are real = p1-p2 and imag = p3-p1-p2, carried at 2*WIDTH_R_I+4 bits.
REQ-021 Scaling: when SHIFT>0, add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT; when SHIFT=0, pass through.
REQ-022 The scaled value is reduced to OUT_W bits per REQ-030/REQ-031.
REQ-023 The pipeline advances as a whole when adv = out_ready | ~out_valid; in_ready = adv, combinational.
REQ-024 When adv=0, all stage registers and out hold their values.
REQ-025 Bubbles propagate as stage-valid=0 and are not collapsed.
REQ-026 Data registers of a stage load only when that stage's incoming valid is 1 (operand gating for power); invalid stages keep their previous data.
REQ-027 An input transfer and an output transfer in the same cycle are both honoured, with no loss and no duplication.

Reset
REQ-028 While rst_n=0:
- all stage-valid flags and out_valid are 0
- out and all data registers are 0
- in_ready is 1
REQ-029 Reset mid-operation discards all in-flight results; the first post-reset output is the first pair accepted after rst_n rises.

Configuration
REQ-030 With CMULT_SAT_EN defined, each component is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-031 Without CMULT_SAT_EN, each component is truncated to its low OUT_W bits (two's-complement wrap).

Structure
REQ-032 Package cmult_pkg holds:
- internal width functions (pre-add W+1, product 2W+2, sum 2W+4)
- the rounding constant function
- the packing helpers for {real, imag}
REQ-033 Sub-module complx_round_sat implements the stage-3 add/shift/saturate for one component; it is instantiated twice (real, imag).

Verification (W=16, OUT_W=16, SHIFT=15)
REQ-034 Basic product: a=0x4000_4000, b=0x4000_C000, conj_b=0 -> out=0x4000_0000 three cycles later.
REQ-035 Conjugate: same a and b with conj_b=1 -> out=0x0000_4000.
REQ-036 Overflow: a=0x8000_0000, b=0x8000_0000 -> out=0x7FFF_0000 with CMULT_SAT_EN, 0x8000_0000 without.
REQ-037 Rounding: a=0x0001_0000, b=0x4000_0000 -> out=0x0001_0000 (half LSB rounds up).
REQ-038 Backpressure: stream 10 random pairs with out_ready held 0 for cycles 4..8 -> out and out_valid stable while stalled, in_ready=0 during the stall, all 10 results match the model in order.
REQ-039 Reset mid-operation: pull rst_n low with 3 results in flight -> out_valid=0 and out=0 immediately, no stale result after release.
